// File: rtl/sramlike_axi_bridge.sv
// SRAM-like (req/addr_ok/data_ok) to AXI read/write bridge, one transfer in flight.
// Define BRIDGE_PERF_CNT_EN to add read/write/stall performance counters.
`timescale 1ns/1ps
module sramlike_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
`ifdef BRIDGE_PERF_CNT_EN
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;

    logic        w_r_done;
    logic        w_b_done;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_ok;
    logic        w_w_ok;
    logic [3:0]  w_wstrb;
    logic        w_unused;

    assign w_r_done = r_rready & rvalid;
    assign w_b_done = r_bready & bvalid;
    assign w_aw_hs  = r_awvalid & awready;
    assign w_w_hs   = r_wvalid & wready;
    assign w_aw_ok  = r_aw_done | w_aw_hs;
    assign w_w_ok   = r_w_done | w_w_hs;
    // Response code is not reported back to the cache.
    assign w_unused = ^rresp;

    always_comb begin
        w_wstrb = 4'b1111;
        case (r_size)
            2'd0:    w_wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sram_req) begin
                        r_size  <= sram_size;
                        r_addr  <= sram_addr;
                        r_wdata <= sram_wdata;
                        if (sram_wr) begin
                            r_state   <= S_AW_W;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // Address and data may finish in either order.
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_addr_ok = (r_state == S_IDLE) & sram_req;
    assign sram_data_ok = w_r_done | w_b_done;
    assign sram_rdata   = w_r_done ? rdata : 32'd0;

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = w_wstrb;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_r_done)
                r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_b_done)
                r_wr_cnt <= r_wr_cnt + 32'd1;
            if (r_state != S_IDLE)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_rd_cnt    = r_rd_cnt;
    assign perf_wr_cnt    = r_wr_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Scoreboard bench for sramlike_axi_bridge: directed timing cases then random traffic.
// Perf counter checks compile in when BRIDGE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp;
    logic [3:0]  wstrb;
`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    // mode 1: main sequence scripts the slave; mode 0: random slave
    logic        mode;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata;
    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    assign arready = mode ? s_arready : m_arready;
    assign rvalid  = mode ? s_rvalid  : m_rvalid;
    assign rdata   = mode ? s_rdata   : m_rdata;
    assign rresp   = mode ? 2'b10     : m_rresp;
    assign awready = mode ? s_awready : m_awready;
    assign wready  = mode ? s_wready  : m_wready;
    assign bvalid  = mode ? s_bvalid  : m_bvalid;

    always #5 clk = ~clk;

    sramlike_axi_bridge dut (
        .clk(clk), .rst(rst),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
`ifdef BRIDGE_PERF_CNT_EN
        .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    typedef struct { logic [31:0] a; logic [2:0] sz; } addr_t;
    typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
    typedef struct { bit wr; logic [31:0] d; int acc; } rsp_t;

    addr_t  ar_q[$];
    addr_t  aw_q[$];
    wbeat_t w_q[$];
    rsp_t   rsp_q[$];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int n_dok = 0;
    int m_rd = 0, m_wr = 0, m_st = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] f_mem(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Enabled lanes are the naturally aligned 2^size-byte window holding addr.
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int n, off;
        logic [3:0] s;
        n = (sz >= 2) ? 4 : (1 << sz);
        off = (int'(a[1:0]) / n) * n;
        s = 4'b0000;
        for (int i = 0; i < 4; i++)
            s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called right after a negedge; returns #1 after the accepting negedge.
    task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input bit push_rsp, output int waited);
        bit got;
        rsp_t r;
        got = 0;
        waited = 0;
        sram_req = 1'b1;
        sram_wr = wr;
        sram_size = sz;
        sram_addr = a;
        sram_wdata = wd;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (sram_addr_ok) got = 1;
            else begin
                waited++;
                @(negedge clk);
            end
        end
        check("accept", {31'd0, got}, 32'd1);
        if (got) begin
            if (wr) begin
                aw_q.push_back('{a: a, sz: {1'b0, sz}});
                w_q.push_back('{d: wd, s: exp_strb(sz, a)});
            end else begin
                ar_q.push_back('{a: a, sz: {1'b0, sz}});
            end
            if (push_rsp) begin
                r.wr = wr;
                r.d = wr ? 32'd0 : rd;
                r.acc = cyc;
                rsp_q.push_back(r);
            end
        end
    endtask

    // Monitor: compares every AXI handshake and completion against the queues.
    initial begin
        addr_t  ea;
        wbeat_t ew;
        rsp_t   er;
        forever begin
            @(negedge clk);
            #2;
            if (arvalid && arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
                else begin
                    ea = ar_q.pop_front();
                    check("araddr", araddr, ea.a);
                    check("arsize", {29'd0, arsize}, {29'd0, ea.sz});
                    check("arid", {28'd0, arid}, 32'd0);
                end
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
                else begin
                    ea = aw_q.pop_front();
                    check("awaddr", awaddr, ea.a);
                    check("awsize", {29'd0, awsize}, {29'd0, ea.sz});
                    check("awid", {28'd0, awid}, 32'd0);
                end
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
                else begin
                    ew = w_q.pop_front();
                    check("wdata", wdata, ew.d);
                    check("wstrb", {28'd0, wstrb}, {28'd0, ew.s});
                end
            end
            if (sram_data_ok) begin
                n_dok++;
                if (rsp_q.size() == 0) check("dok_unexpected", 32'd1, 32'd0);
                else begin
                    er = rsp_q.pop_front();
                    check("rsp_kind", {31'd0, bready}, {31'd0, er.wr});
                    check("rsp_data", sram_rdata, er.d);
                    if (er.wr) m_wr++;
                    else m_rd++;
                    m_st += cyc - er.acc;
                end
            end else if (rvalid) begin
                check("rdata_gated", sram_rdata, 32'd0);
            end
        end
    end

    // Random AXI slave, honouring valid-hold and read/write ordering.
    initial begin
        logic [31:0] rd_pend[$];
        int aw_n, w_n, b_n;
        bit r_hs, b_hs;
        aw_n = 0; w_n = 0; b_n = 0; r_hs = 0; b_hs = 0;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(negedge clk);
            if (mode) begin
                m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0;
                m_bvalid = 0; rd_pend.delete();
                aw_n = 0; w_n = 0; b_n = 0; r_hs = 0; b_hs = 0;
            end else begin
                if (r_hs) begin
                    m_rvalid = 0;
                    if (rd_pend.size() > 0) rd_pend.delete(0);
                    r_hs = 0;
                end
                if (b_hs) begin
                    m_bvalid = 0;
                    b_n--;
                    b_hs = 0;
                end
                if (aw_n > 0 && w_n > 0) begin
                    aw_n--; w_n--; b_n++;
                end
                m_arready = ($urandom % 3) != 0;
                m_awready = ($urandom % 3) != 0;
                m_wready  = ($urandom % 3) != 0;
                if (!m_rvalid && rd_pend.size() > 0 && ($urandom % 2) == 1) begin
                    m_rvalid = 1;
                    m_rdata = f_mem(rd_pend[0]);
                    m_rresp = 2'($urandom);
                end
                if (!m_bvalid && b_n > 0 && ($urandom % 2) == 1)
                    m_bvalid = 1;
                #1;
                if (arvalid && arready) rd_pend.push_back(araddr);
                if (rvalid && rready) r_hs = 1;
                if (awvalid && awready) aw_n++;
                if (wvalid && wready) w_n++;
                if (bvalid && bready) b_hs = 1;
            end
        end
    end

    initial begin
        int w, d0, base_rd, base_wr, base_st;
        logic [31:0] ra, rw;
        logic [1:0] rs;
        bit rwr;
        rst = 1; mode = 1;
        sram_req = 0; sram_wr = 0; sram_size = 0; sram_addr = 0; sram_wdata = 0;
        s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
        s_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        check("rst_dok", {31'd0, sram_data_ok}, 32'd0);

        // Read with immediate slave
        @(negedge clk);
        s_arready = 1; s_rvalid = 1; s_rdata = 32'h3C08_0001;
        issue(0, 2'd2, 32'hBFC0_0000, 0, 32'h3C08_0001, 1, w);
        check("t1_accept_T", w, 0);
        @(negedge clk); sram_req = 0; #1;
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr", araddr, 32'hBFC0_0000);
        check("t1_arsize", {29'd0, arsize}, 32'd2);
        check("t1_dok_T1", {31'd0, sram_data_ok}, 32'd0);
        @(negedge clk); #1;
        check("t1_dok_T2", {31'd0, sram_data_ok}, 32'd1);
        check("t1_rdata", sram_rdata, 32'h3C08_0001);
        @(negedge clk); #1;
        check("t1_dok_T3", {31'd0, sram_data_ok}, 32'd0);
        check("t1_stray_r", sram_rdata, 32'd0);

        // Read with arready stalled 3 cycles, rvalid 2 cycles late
        @(negedge clk);
        s_arready = 0; s_rvalid = 0; s_rdata = 32'hCAFE_F00D;
        d0 = n_dok;
        issue(0, 2'd1, 32'h8000_1002, 0, 32'hCAFE_F00D, 1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); sram_addr = 32'h5555_0000 + i; #1;
            check("t2_arvalid_hold", {31'd0, arvalid}, 32'd1);
            check("t2_araddr_hold", araddr, 32'h8000_1002);
            check("t2_no_addr_ok", {31'd0, sram_addr_ok}, 32'd0);
        end
        @(negedge clk); s_arready = 1; #1;
        check("t2_arvalid_hs", {31'd0, arvalid}, 32'd1);
        @(negedge clk); s_arready = 0; #1;
        check("t2_arvalid_drop", {31'd0, arvalid}, 32'd0);
        check("t2_rready", {31'd0, rready}, 32'd1);
        check("t2_no_addr_ok_r", {31'd0, sram_addr_ok}, 32'd0);
        @(negedge clk); #1;
        check("t2_dok_wait", {31'd0, sram_data_ok}, 32'd0);
        @(negedge clk); s_rvalid = 1; sram_req = 0; #1;
        check("t2_dok", {31'd0, sram_data_ok}, 32'd1);
        @(negedge clk); s_rvalid = 0; #1;
        check("t2_single_dok", n_dok - d0, 1);

        // Writes with immediate slave: byte lane 3, then upper half
        @(negedge clk);
        s_awready = 1; s_wready = 1; s_bvalid = 1;
        issue(1, 2'd0, 32'h0000_0003, 32'hABAB_ABAB, 0, 1, w);
        @(negedge clk); sram_req = 0; #1;
        check("t3_wstrb_b3", {28'd0, wstrb}, 32'h8);
        check("t3_awsize_b", {29'd0, awsize}, 32'd0);
        @(negedge clk); #1;
        check("t3_dok_b", {31'd0, sram_data_ok}, 32'd1);
        @(negedge clk);
        issue(1, 2'd1, 32'h0000_0002, 32'h1234_1234, 0, 1, w);
        @(negedge clk); sram_req = 0; #1;
        check("t3_wstrb_h2", {28'd0, wstrb}, 32'hC);
        check("t3_awsize_h", {29'd0, awsize}, 32'd1);
        @(negedge clk); #1;
        check("t3_dok_h", {31'd0, sram_data_ok}, 32'd1);

        // Write with wready at T+1, awready at T+3
        @(negedge clk);
        s_awready = 0; s_wready = 0; s_bvalid = 0;
        issue(1, 2'd2, 32'h1000_0010, 32'hDEAD_BEEF, 0, 1, w);
        @(negedge clk); sram_req = 0; s_wready = 1; #1;
        check("t4_aw_T1", {31'd0, awvalid}, 32'd1);
        check("t4_w_T1", {31'd0, wvalid}, 32'd1);
        @(negedge clk); s_wready = 0; #1;
        check("t4_w_T2", {31'd0, wvalid}, 32'd0);
        check("t4_aw_T2", {31'd0, awvalid}, 32'd1);
        @(negedge clk); s_awready = 1; #1;
        check("t4_aw_T3", {31'd0, awvalid}, 32'd1);
        check("t4_b_T3", {31'd0, bready}, 32'd0);
        @(negedge clk); s_awready = 0; #1;
        check("t4_aw_T4", {31'd0, awvalid}, 32'd0);
        check("t4_b_T4", {31'd0, bready}, 32'd1);
        check("t4_dok_T4", {31'd0, sram_data_ok}, 32'd0);
        @(negedge clk); s_bvalid = 1; #1;
        check("t4_dok_T5", {31'd0, sram_data_ok}, 32'd1);
        @(negedge clk); s_bvalid = 0;

        // Back-to-back reads with req held high
        @(negedge clk);
        s_arready = 1; s_rvalid = 1; s_rdata = 32'h1111_2222;
        issue(0, 2'd2, 32'h0000_0100, 0, 32'h1111_2222, 1, w);
        @(negedge clk); #1;
        check("t5_busy_T1", {31'd0, sram_addr_ok}, 32'd0);
        @(negedge clk); #1;
        check("t5_dok_T2", {31'd0, sram_data_ok}, 32'd1);
        check("t5_busy_T2", {31'd0, sram_addr_ok}, 32'd0);
        @(negedge clk);
        issue(0, 2'd2, 32'h0000_0104, 0, 32'h1111_2222, 1, w);
        check("t5_second_T3", w, 0);
        @(negedge clk); sram_req = 0;
        @(negedge clk); #1;
        check("t5_dok2", {31'd0, sram_data_ok}, 32'd1);
        @(negedge clk); s_rvalid = 0;

        // Reset while in R, then a stray rvalid
        @(negedge clk);
        s_arready = 1; s_rvalid = 0;
        issue(0, 2'd2, 32'h0000_0200, 0, 0, 0, w);
        @(negedge clk); sram_req = 0;
        @(negedge clk); s_arready = 0; #1;
        check("t6_rready_in_R", {31'd0, rready}, 32'd1);
        rst = 1;
        @(negedge clk); rst = 0; s_rvalid = 1; #1;
        check("t6_rready_rst", {31'd0, rready}, 32'd0);
        check("t6_no_dok", {31'd0, sram_data_ok}, 32'd0);
        @(negedge clk); #1;
        check("t6_no_dok2", {31'd0, sram_data_ok}, 32'd0);
        s_rvalid = 0;
        base_rd = m_rd; base_wr = m_wr; base_st = m_st;

        // 3 reads and 1 write through an immediate slave
        s_arready = 1; s_rvalid = 1; s_rdata = 32'h0BAD_F00D;
        s_awready = 1; s_wready = 1; s_bvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(i == 3, 2'd2, 32'h0000_0400 + 32'(i * 4), 32'h7777_0000 + i,
                  32'h0BAD_F00D, 1, w);
            @(negedge clk); sram_req = 0;
            @(negedge clk);
        end
        @(negedge clk); #1;
        check("t7_all_done", rsp_q.size(), 0);
`ifdef BRIDGE_PERF_CNT_EN
        check("perf_rd_3", perf_rd_cnt, 32'd3);
        check("perf_wr_1", perf_wr_cnt, 32'd1);
        check("perf_stall_a", perf_stall_cnt, 32'(m_st - base_st));
`endif
        s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;

        // Random traffic against the random slave
        @(negedge clk);
        mode = 0;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rwr = ($urandom % 2) == 1;
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            rw = $urandom;
            issue(rwr, rs, ra, rw, f_mem(ra), 1, w);
            @(negedge clk);
            sram_req = 0;
        end
        for (int k = 0; k < 1000 && rsp_q.size() > 0; k++) @(negedge clk);
        #3;
        check("drain_rsp", rsp_q.size(), 0);
        check("drain_ar", ar_q.size(), 0);
        check("drain_w", w_q.size(), 0);
`ifdef BRIDGE_PERF_CNT_EN
        check("perf_rd_end", perf_rd_cnt, 32'(m_rd - base_rd));
        check("perf_wr_end", perf_wr_cnt, 32'(m_wr - base_wr));
        check("perf_stall_end", perf_stall_cnt, 32'(m_st - base_st));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
